// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU front end: the default
// operand and select widths, and the state encoding of the arbiter FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int SEL_W_DEF     = 4;

    // IDLE: waiting for a request; EXEC: operation on the ALU bus;
    // RESP: result offered to the consumer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   valid0, valid1 : requests from requester 0 / 1
//   ptr            : preferred requester when both are valid
//   grant          : one-hot grant, bit N = requester N; zero if no request
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters. A request
// is granted in IDLE, presented to the ALU for one EXEC cycle, and its
// result is held in RESP until the consumer takes it. One operation is in
// flight at a time (one result per 3 cycles at best).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    : request handshake, N = 0, 1
//   reqN_data_1/_2, reqN_sel   : operands and ALU select of requester N
//   alu_data_1/_2, alu_sel     : registered operation driven to the ALU
//   alu_out, alu_zero_flag     : ALU result and zero flag
//   rsp_valid / rsp_ready      : response handshake
//   rsp_data, rsp_zero, rsp_id : captured result, zero flag, owner index
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int SEL_W     = SEL_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_SIZE-1:0] req0_data_1,
    input  logic [WORD_SIZE-1:0] req0_data_2,
    input  logic [SEL_W-1:0]     req0_sel,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_SIZE-1:0] req1_data_1,
    input  logic [WORD_SIZE-1:0] req1_data_2,
    input  logic [SEL_W-1:0]     req1_sel,

    output logic [WORD_SIZE-1:0] alu_data_1,
    output logic [WORD_SIZE-1:0] alu_data_2,
    output logic [SEL_W-1:0]     alu_sel,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_zero_flag,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_id
);

    state_t               state;
    state_t               state_next;
    logic                 ptr;
    logic [1:0]           grant;
    logic                 grant_any;
    logic                 take;
    logic [WORD_SIZE-1:0] op_data_1;
    logic [WORD_SIZE-1:0] op_data_2;
    logic [SEL_W-1:0]     op_sel;

    rr_arb2 u_rr_arb2 (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (ptr),
        .grant  (grant)
    );

    assign grant_any = |grant;
    assign take      = (state == ST_IDLE) && grant_any;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (grant_any) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic. The arbiter keeps granting combinationally while the
    // state register is held in reset, so ready is qualified by rst_n to
    // keep it low for the whole reset window.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req0_ready = rst_n && grant[0];
                req1_ready = rst_n && grant[1];
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operation and response registers. The operation registers feed the
    // ALU bus directly, so the bus keeps the last operation between grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            op_data_1 <= '0;
            op_data_2 <= '0;
            op_sel    <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            if (take) begin
                op_data_1 <= grant[1] ? req1_data_1 : req0_data_1;
                op_data_2 <= grant[1] ? req1_data_2 : req0_data_2;
                op_sel    <= grant[1] ? req1_sel    : req0_sel;
                rsp_id    <= grant[1];
                // Prefer the requester that was not just served.
                ptr       <= ~grant[1];
            end
            if (state == ST_EXEC) begin
                rsp_data <= alu_out;
                rsp_zero <= alu_zero_flag;
            end
        end
    end

    assign alu_data_1 = op_data_1;
    assign alu_data_2 = op_data_2;
    assign alu_sel    = op_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with a behavioural ALU attached.
// The reference model works on a transaction timeline: when no operation
// is outstanding the expected winner follows the round-robin rules; once
// granted at cycle G the response is due at G+2 and lasts until accepted.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_ready, req1_ready;
    logic [7:0] alu_data_1, alu_data_2, alu_out;
    logic [3:0] alu_sel;
    logic       alu_zero_flag;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero, rsp_id;

    // Requester-side stimulus state
    logic       v   [2];
    logic [7:0] d1  [2];
    logic [7:0] d2  [2];
    logic [3:0] sel [2];

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural ALU: 0 add, 1 subtract, 2 and, 3 or, others xor
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
        int r;
        case (s)
            4'd0:    r = (int'(a) + int'(b)) % 256;
            4'd1:    r = (int'(a) - int'(b) + 256) % 256;
            4'd2:    r = int'(a & b);
            4'd3:    r = int'(a | b);
            default: r = int'(a ^ b);
        endcase
        return 8'(r);
    endfunction

    assign alu_out       = alu_ref(alu_data_1, alu_data_2, alu_sel);
    assign alu_zero_flag = (alu_out == 8'd0);

    alu_arbiter #(.WORD_SIZE(8), .SEL_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (v[0]),
        .req0_ready    (req0_ready),
        .req0_data_1   (d1[0]),
        .req0_data_2   (d2[0]),
        .req0_sel      (sel[0]),
        .req1_valid    (v[1]),
        .req1_ready    (req1_ready),
        .req1_data_1   (d1[1]),
        .req1_data_2   (d2[1]),
        .req1_sel      (sel[1]),
        .alu_data_1    (alu_data_1),
        .alu_data_2    (alu_data_2),
        .alu_sel       (alu_sel),
        .alu_out       (alu_out),
        .alu_zero_flag (alu_zero_flag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_zero      (rsp_zero),
        .rsp_id        (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int         cyc   = 0;
    bit         busy  = 0;
    int         gcyc  = 0;
    int         pref  = 0;
    logic [7:0] l_d1  = 0, l_d2 = 0, e_res = 0;
    logic [3:0] l_sel = 0;
    bit         e_zero = 0, e_id = 0;
    int         grant_log[$];
    int         mode = 0;   // 0: drop after grant, 1: random, 2: keep valid

    // Observations for the directed scenarios
    bit         seen_rsp = 0;
    int         obs_lat  = -1;
    logic [7:0] obs_data = 0;
    logic       obs_zero = 0, obs_id = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int i);
        v[i]   = 1'($urandom_range(0, 1));
        d1[i]  = 8'($urandom);
        d2[i]  = 8'($urandom);
        sel[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s);
        v[i] = 1'b1; d1[i] = a; d2[i] = b; sel[i] = s;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
        chk({tag, "_rsp_valid"},  32'(rsp_valid),  0);
        chk({tag, "_rsp_data"},   32'(rsp_data),   0);
        chk({tag, "_rsp_zero"},   32'(rsp_zero),   0);
        chk({tag, "_rsp_id"},     32'(rsp_id),     0);
        chk({tag, "_alu_data_1"}, 32'(alu_data_1), 0);
        chk({tag, "_alu_data_2"}, 32'(alu_data_2), 0);
        chk({tag, "_alu_sel"},    32'(alu_sel),    0);
    endtask

    task automatic model_reset();
        busy = 0; pref = 0;
        l_d1 = 0; l_d2 = 0; l_sel = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance, then update
    // the stimulus just after the rising edge.
    task automatic step();
        int g;
        g = -1;
        @(negedge clk);
        chk("alu_data_1", 32'(alu_data_1), 32'(l_d1));
        chk("alu_data_2", 32'(alu_data_2), 32'(l_d2));
        chk("alu_sel",    32'(alu_sel),    32'(l_sel));
        if (!busy) begin
            if (v[0] && v[1]) g = pref;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
            chk("req0_ready", 32'(req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(req1_ready), 32'(g == 1));
            chk("rsp_valid_idle", 32'(rsp_valid), 0);
            if (g >= 0) begin
                busy   = 1;
                gcyc   = cyc;
                l_d1   = d1[g];
                l_d2   = d2[g];
                l_sel  = sel[g];
                e_res  = alu_ref(d1[g], d2[g], sel[g]);
                e_zero = (e_res == 8'd0);
                e_id   = (g == 1);
                pref   = 1 - g;
                seen_rsp = 0;
                grant_log.push_back(g);
            end
        end else begin
            chk("req0_ready_busy", 32'(req0_ready), 0);
            chk("req1_ready_busy", 32'(req1_ready), 0);
            chk("rsp_valid", 32'(rsp_valid), 32'(cyc >= gcyc + 2));
            if (rsp_valid) begin
                if (!seen_rsp) begin
                    obs_lat  = cyc - gcyc;
                    seen_rsp = 1;
                end
                obs_data = rsp_data;
                obs_zero = rsp_zero;
                obs_id   = rsp_id;
            end
            if (cyc >= gcyc + 2) begin
                chk("rsp_data", 32'(rsp_data), 32'(e_res));
                chk("rsp_zero", 32'(rsp_zero), 32'(e_zero));
                chk("rsp_id",   32'(rsp_id),   32'(e_id));
                if (rsp_ready) busy = 0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (g >= 0) begin
            if (mode == 1)      new_req(g);
            else if (mode == 0) v[g] = 1'b0;
        end
        if (mode == 1) begin
            for (int i = 0; i < 2; i++)
                if (!v[i] && $urandom_range(0, 2) == 0) new_req(i);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int nlog;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) set_req(i, 8'hAA, 8'h55, 4'd0);

        // Reset state, with both requesters asking
        #7;
        check_reset("init");
        v[0] = 1'b0; v[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // req0 alone: 0xFC + 0x01
        set_req(0, 8'hFC, 8'h01, 4'd0);
        repeat (4) step();
        chk("s1_latency", 32'(obs_lat),  2);
        chk("s1_data",    32'(obs_data), 32'h0FD);
        chk("s1_zero",    32'(obs_zero), 0);
        chk("s1_id",      32'(obs_id),   0);

        // Reset during EXEC abandons the operation
        set_req(0, 8'h12, 8'h34, 4'd0);
        step();
        #2;
        rst_n = 1'b0;
        v[1] = 1'b1;
        #1;
        check_reset("mid");
        v[1] = 1'b0;
        model_reset();
        seen_rsp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) step();
        chk("mid_no_rsp", 32'(seen_rsp), 0);

        // Both requesters valid continuously: grants alternate from req0
        grant_log.delete();
        mode = 2;
        set_req(0, 8'h10, 8'h03, 4'd1);
        set_req(1, 8'h20, 8'h07, 4'd0);
        repeat (12) step();
        mode = 0;
        v[0] = 1'b0; v[1] = 1'b0;
        repeat (3) step();
        nlog = grant_log.size();
        chk("alt_count", 32'(nlog), 4);
        for (int i = 0; i < 4 && i < nlog; i++)
            chk("alt_grant", 32'(grant_log[i]), 32'(i % 2));

        // req1: 5 - 5, consumer stalls 4 RESP cycles while req0 waits
        grant_log.delete();
        rsp_ready = 1'b0;
        set_req(1, 8'h05, 8'h05, 4'd1);
        step();
        set_req(0, 8'h30, 8'h0C, 4'd4);
        repeat (5) step();
        chk("stall_grants", 32'(grant_log.size()), 1);
        chk("stall_data",   32'(obs_data), 0);
        chk("stall_zero",   32'(obs_zero), 1);
        chk("stall_id",     32'(obs_id),   1);
        rsp_ready = 1'b1;
        repeat (5) step();
        chk("stall_waiter_served", 32'(grant_log.size()), 2);

        // Wrap-around: 0xFF + 0x01
        set_req(0, 8'hFF, 8'h01, 4'd0);
        repeat (4) step();
        chk("wrap_data", 32'(obs_data), 0);
        chk("wrap_zero", 32'(obs_zero), 1);

        // Randomized traffic
        mode = 1;
        new_req(0);
        new_req(1);
        repeat (400) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
